// File: rtl/irrigation_actuator_ctrl.sv
// Actuator stage: filters the controller state code, sequences valve/pump/alarm drives
// and counts ALARM entries. Define IRRIG_ERR_LATCH_EN to make ALARM sticky until VZ.
module irrigation_actuator_ctrl #(
  parameter int STABLE     = 4,
  parameter int PUMP_DELAY = 8,
  parameter int BLINK      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] state_in,
  output logic       valve_en,
  output logic       pump_en,
  output logic       alarm,
  output logic [1:0] q_state,
  output logic [2:0] seq_state,
  output logic [7:0] err_count
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int DW = $clog2(PUMP_DELAY + 1);
  localparam int BW = $clog2(BLINK + 1);
  localparam logic [SW-1:0] STABLE_C   = SW'(STABLE);
  localparam logic [SW-1:0] STABLE_M1  = SW'(STABLE - 1);
  localparam logic [DW-1:0] DELAY_LOAD = DW'(PUMP_DELAY - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK - 1);

  localparam logic [1:0] C_VZ   = 2'b00;
  localparam logic [1:0] C_EN   = 2'b01;
  localparam logic [1:0] C_REGA = 2'b11;
  localparam logic [1:0] C_ERRO = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_FILL      = 3'b001,
    S_PUMP_WAIT = 3'b010,
    S_IRRIGATE  = 3'b011,
    S_ALARM     = 3'b100
  } seq_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic seq_t map_code(input logic [1:0] c);
    case (c)
      C_EN:    return S_FILL;
      C_REGA:  return S_PUMP_WAIT;
      C_ERRO:  return S_ALARM;
      default: return S_IDLE;
    endcase
  endfunction

  logic [1:0]    cand;
  logic [SW-1:0] scnt;
  logic [DW-1:0] dcnt, dcnt_d;
  logic [BW-1:0] bcnt, bcnt_d;
  seq_t          st, seq_next;
  logic          valve_d, pump_d, alarm_d;
  logic [7:0]    err_d;

  // Stability filter: reset leaves VZ already qualified
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand    <= C_VZ;
      scnt    <= STABLE_C;
      q_state <= C_VZ;
    end else if (state_in != cand) begin
      cand <= state_in;
      scnt <= SW'(1);
    end else if (scnt != STABLE_C) begin
      scnt <= scnt + SW'(1);
      if (scnt == STABLE_M1) q_state <= cand;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= seq_next;
  end

  always_comb begin
    seq_next = map_code(q_state);
    case (st)
      S_PUMP_WAIT: if (q_state == C_REGA) seq_next = (dcnt == '0) ? S_IRRIGATE : S_PUMP_WAIT;
      S_IRRIGATE:  if (q_state == C_REGA) seq_next = S_IRRIGATE;
      S_ALARM: begin
`ifdef IRRIG_ERR_LATCH_EN
        seq_next = (q_state == C_VZ) ? S_IDLE : S_ALARM;
`else
        seq_next = map_code(q_state);
`endif
      end
      default: ;
    endcase
  end

  // Drives are computed from the next state so they register alongside seq_state
  always_comb begin
    valve_d = (seq_next == S_FILL);
    pump_d  = (seq_next == S_IRRIGATE);
    dcnt_d  = dcnt;
    alarm_d = 1'b0;
    bcnt_d  = '0;
    err_d   = err_count;
    if (seq_next == S_PUMP_WAIT)
      dcnt_d = (st != S_PUMP_WAIT) ? DELAY_LOAD : dcnt - DW'(1);
    if (seq_next == S_ALARM) begin
      if (st != S_ALARM) begin
        alarm_d = 1'b1;
        err_d   = sat_inc8(err_count);
      end else if (bcnt == BLINK_LAST) begin
        alarm_d = ~alarm;
      end else begin
        alarm_d = alarm;
        bcnt_d  = bcnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valve_en  <= 1'b0;
      pump_en   <= 1'b0;
      alarm     <= 1'b0;
      dcnt      <= '0;
      bcnt      <= '0;
      err_count <= 8'd0;
    end else begin
      valve_en  <= valve_d;
      pump_en   <= pump_d;
      alarm     <= alarm_d;
      dcnt      <= dcnt_d;
      bcnt      <= bcnt_d;
      err_count <= err_d;
    end
  end

  assign seq_state = st;

endmodule

// File: tb/tb_irrigation_actuator_ctrl.sv
// Directed bench for irrigation_actuator_ctrl with default parameters
// (STABLE=4, PUMP_DELAY=8, BLINK=16); honours IRRIG_ERR_LATCH_EN if defined.
module tb_irrigation_actuator_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] state_in;
  logic       valve_en, pump_en, alarm;
  logic [1:0] q_state;
  logic [2:0] seq_state;
  logic [7:0] err_count;

  int checks = 0;
  int passed = 0;
  int excl_bad = 0;

  irrigation_actuator_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .state_in (state_in),
    .valve_en (valve_en),
    .pump_en  (pump_en),
    .alarm    (alarm),
    .q_state  (q_state),
    .seq_state(seq_state),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (valve_en && pump_en) excl_bad++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    state_in = 2'b00;
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    state_in = 2'b00;
    #1;
    checks++; if ({valve_en, pump_en, alarm} !== 3'b000) $display("FAIL rst_drives: got %b want 000", {valve_en, pump_en, alarm}); else passed++;
    checks++; if ({q_state, seq_state} !== 5'b0) $display("FAIL rst_state: got q=%b seq=%b want 00/000", q_state, seq_state); else passed++;
    checks++; if (err_count !== 8'd0) $display("FAIL rst_err: got %0d want 0", err_count); else passed++;
    tick(2);
    reset = 1'b1;
    tick(3);
    checks++; if ({q_state, seq_state, valve_en, pump_en, alarm} !== 8'b0) $display("FAIL rst_idle: got %b want 0", {q_state, seq_state, valve_en, pump_en, alarm}); else passed++;
  endtask

  task automatic test_fill_pump();
    int pump_hi, valve_hi;
    apply_reset();
    state_in = 2'b01;
    tick(3);
    checks++; if (q_state !== 2'b00) $display("FAIL fill_q_early: got %b want 00", q_state); else passed++;
    tick(1);
    checks++; if (q_state !== 2'b01 || valve_en !== 1'b0) $display("FAIL fill_q_edge3: got q=%b valve=%b want 01/0", q_state, valve_en); else passed++;
    tick(1);
    checks++; if (valve_en !== 1'b1 || seq_state !== 3'b001) $display("FAIL fill_valve_edge4: got valve=%b seq=%b want 1/001", valve_en, seq_state); else passed++;
    state_in = 2'b11;
    tick(4);
    checks++; if (q_state !== 2'b11) $display("FAIL rega_q: got %b want 11", q_state); else passed++;
    pump_hi = 0; valve_hi = 0;
    repeat (8) begin
      tick(1);
      if (pump_en) pump_hi++;
      if (valve_en) valve_hi++;
    end
    checks++; if (pump_hi !== 0 || valve_hi !== 0) $display("FAIL rega_wait: got pump_hi=%0d valve_hi=%0d want 0/0", pump_hi, valve_hi); else passed++;
    tick(1);
    checks++; if (pump_en !== 1'b1 || valve_en !== 1'b0 || seq_state !== 3'b011) $display("FAIL rega_pump_edge9: got pump=%b valve=%b seq=%b want 1/0/011", pump_en, valve_en, seq_state); else passed++;
  endtask

  task automatic test_glitch();
    int bad;
    apply_reset();
    bad = 0;
    state_in = 2'b10;
    repeat (3) begin
      tick(1);
      if (q_state !== 2'b00 || alarm !== 1'b0 || err_count !== 8'd0) bad++;
    end
    state_in = 2'b00;
    repeat (8) begin
      tick(1);
      if (q_state !== 2'b00 || alarm !== 1'b0 || err_count !== 8'd0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL glitch_reject: got %0d bad cycles want 0", bad); else passed++;
    checks++; if (seq_state !== 3'b000) $display("FAIL glitch_seq: got %b want 000", seq_state); else passed++;
  endtask

  task automatic test_alarm();
    apply_reset();
    state_in = 2'b10;
    tick(5);
    checks++; if (alarm !== 1'b1 || seq_state !== 3'b100 || err_count !== 8'd1) $display("FAIL alarm_entry: got alarm=%b seq=%b err=%0d want 1/100/1", alarm, seq_state, err_count); else passed++;
    tick(15);
    checks++; if (alarm !== 1'b1) $display("FAIL alarm_15: got %b want 1", alarm); else passed++;
    tick(1);
    checks++; if (alarm !== 1'b0 || valve_en !== 1'b0 || pump_en !== 1'b0) $display("FAIL alarm_16: got alarm=%b valve=%b pump=%b want 0/0/0", alarm, valve_en, pump_en); else passed++;
    tick(15);
    checks++; if (alarm !== 1'b0) $display("FAIL alarm_31: got %b want 0", alarm); else passed++;
    tick(1);
    checks++; if (alarm !== 1'b1) $display("FAIL alarm_32: got %b want 1", alarm); else passed++;
    repeat (254) begin
      state_in = 2'b00; tick(5);
      state_in = 2'b10; tick(5);
    end
    checks++; if (err_count !== 8'd255) $display("FAIL err_reach_255: got %0d want 255", err_count); else passed++;
    repeat (46) begin
      state_in = 2'b00; tick(5);
      state_in = 2'b10; tick(5);
    end
    checks++; if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d want 255", err_count); else passed++;
    state_in = 2'b00;
    tick(5);
    checks++; if (alarm !== 1'b0 || seq_state !== 3'b000) $display("FAIL alarm_exit: got alarm=%b seq=%b want 0/000", alarm, seq_state); else passed++;
  endtask

  task automatic test_pump_abort();
    int pump_hi;
    apply_reset();
    state_in = 2'b11;
    tick(5);
    checks++; if (seq_state !== 3'b010) $display("FAIL abort_wait_entry: got %b want 010", seq_state); else passed++;
    state_in = 2'b00;
    pump_hi = 0;
    repeat (5) begin
      tick(1);
      if (pump_en) pump_hi++;
    end
    checks++; if (pump_hi !== 0 || seq_state !== 3'b000) $display("FAIL abort_idle: got pump_hi=%0d seq=%b want 0/000", pump_hi, seq_state); else passed++;
    state_in = 2'b11;
    tick(4);
    pump_hi = 0;
    repeat (8) begin
      tick(1);
      if (pump_en) pump_hi++;
    end
    checks++; if (pump_hi !== 0 || seq_state !== 3'b010) $display("FAIL abort_reload: got pump_hi=%0d seq=%b want 0/010", pump_hi, seq_state); else passed++;
    tick(1);
    checks++; if (pump_en !== 1'b1) $display("FAIL abort_repump: got %b want 1", pump_en); else passed++;
  endtask

  task automatic test_latch();
    apply_reset();
    state_in = 2'b10;
    tick(5);
    state_in = 2'b01;
    tick(6);
`ifdef IRRIG_ERR_LATCH_EN
    checks++; if (seq_state !== 3'b100 || valve_en !== 1'b0) $display("FAIL latch_hold: got seq=%b valve=%b want 100/0", seq_state, valve_en); else passed++;
`else
    checks++; if (seq_state !== 3'b001 || valve_en !== 1'b1) $display("FAIL nolatch_fill: got seq=%b valve=%b want 001/1", seq_state, valve_en); else passed++;
`endif
    state_in = 2'b00;
    tick(5);
    checks++; if (seq_state !== 3'b000 || alarm !== 1'b0) $display("FAIL latch_release: got seq=%b alarm=%b want 000/0", seq_state, alarm); else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    state_in = 2'b10; tick(5);
    state_in = 2'b00; tick(5);
    state_in = 2'b11; tick(13);
    checks++; if (pump_en !== 1'b1 || err_count !== 8'd1) $display("FAIL areset_pre: got pump=%b err=%0d want 1/1", pump_en, err_count); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if ({pump_en, seq_state, q_state} !== 6'b0 || err_count !== 8'd0) $display("FAIL areset_now: got pump=%b seq=%b q=%b err=%0d want 0", pump_en, seq_state, q_state, err_count); else passed++;
    state_in = 2'b00;
    #2 reset = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_fill_pump();
    test_glitch();
    test_alarm();
    test_pump_abort();
    test_latch();
    test_async_reset();
    checks++; if (excl_bad !== 0) $display("FAIL valve_pump_exclusive: got %0d overlap cycles want 0", excl_bad); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
